// File: rtl/gnn_param.sv
// gnn_param: time-multiplexed GNN layer pair (neighbour aggregation, dense+ReLU,
// dense) over a runtime adjacency mask, processing one node per AGG/L1/L2 pass.
module gnn_param #(
    parameter int N_NODES = 4,
    parameter int F_IN    = 4,
    parameter int F_HID   = 4,
    parameter int F_OUT   = 2,
    parameter int DW      = 5,
    parameter int ACC_W   = 21,
    parameter int RELU    = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [N_NODES*F_IN*DW-1:0]       x_flat,
    input  logic [F_IN*F_HID*DW-1:0]         w1_flat,
    input  logic [F_HID*F_OUT*DW-1:0]        w2_flat,
    input  logic [N_NODES*N_NODES-1:0]       adj,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [N_NODES*F_OUT*ACC_W-1:0]   out_flat,
    output logic                             busy
);

    localparam int NW = (N_NODES > 1) ? $clog2(N_NODES) : 1;
    localparam int KM = (F_HID > F_OUT) ? F_HID : F_OUT;
    localparam int KW = (KM > 1) ? $clog2(KM) : 1;

    typedef enum logic [2:0] {IDLE, AGG, L1, L2, DONE} state_t;

    state_t                             state_q;
    logic [NW-1:0]                      n_q;
    logic [KW-1:0]                      k_q;
    logic [N_NODES*F_IN*DW-1:0]         x_q;
    logic [F_IN*F_HID*DW-1:0]           w1_q;
    logic [F_HID*F_OUT*DW-1:0]          w2_q;
    logic [N_NODES*N_NODES-1:0]         adj_q;
    logic [N_NODES*F_OUT*ACC_W-1:0]     out_q;
    logic [F_IN-1:0][ACC_W-1:0]         a_q;
    logic [F_HID-1:0][ACC_W-1:0]        hid_q;
    logic                               in_ready_q;
    logic                               out_valid_q;
    logic                               busy_q;

    logic [F_IN-1:0][ACC_W-1:0]         agg_d;
    logic signed [ACC_W-1:0]            hid_d;
    logic signed [ACC_W-1:0]            out_d;

    function automatic logic signed [ACC_W-1:0] sx(input logic [DW-1:0] v);
        return {{(ACC_W-DW){v[DW-1]}}, v};
    endfunction

    // Masked column sums of the captured features for the current node.
    always_comb begin
        agg_d = '0;
        for (int f = 0; f < F_IN; f++) begin
            for (int m = 0; m < N_NODES; m++) begin
                if (adj_q[int'(n_q)*N_NODES + m]) begin
                    agg_d[f] = agg_d[f] + sx(x_q[(m*F_IN+f)*DW +: DW]);
                end
            end
        end
    end

    always_comb begin
        hid_d = '0;
        for (int f = 0; f < F_IN; f++) begin
            hid_d = hid_d + $signed(a_q[f])
                  * sx(w1_q[(f*F_HID+int'(k_q))*DW +: DW]);
        end
    end

    always_comb begin
        out_d = '0;
        for (int h = 0; h < F_HID; h++) begin
            out_d = out_d + $signed(hid_q[h])
                  * sx(w2_q[(h*F_OUT+int'(k_q))*DW +: DW]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            n_q         <= '0;
            k_q         <= '0;
            x_q         <= '0;
            w1_q        <= '0;
            w2_q        <= '0;
            adj_q       <= '0;
            out_q       <= '0;
            a_q         <= '0;
            hid_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q        <= x_flat;
                        w1_q       <= w1_flat;
                        w2_q       <= w2_flat;
                        adj_q      <= adj;
                        n_q        <= '0;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= AGG;
                    end
                end
                AGG: begin
                    a_q     <= agg_d;
                    k_q     <= '0;
                    state_q <= L1;
                end
                L1: begin
                    if (RELU != 0 && hid_d[ACC_W-1]) begin
                        hid_q[k_q] <= '0;
                    end else begin
                        hid_q[k_q] <= hid_d;
                    end
                    if (k_q == KW'(F_HID-1)) begin
                        k_q     <= '0;
                        state_q <= L2;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                L2: begin
                    out_q[(int'(n_q)*F_OUT+int'(k_q))*ACC_W +: ACC_W] <= out_d;
                    if (k_q == KW'(F_OUT-1)) begin
                        k_q <= '0;
                        if (n_q == NW'(N_NODES-1)) begin
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            n_q     <= n_q + NW'(1);
                            state_q <= AGG;
                        end
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_flat  = out_q;

endmodule

// File: tb/tb_gnn_param.sv
// Directed-vector bench for gnn_param: a RELU=1 and a RELU=0 instance run
// in lockstep on the same stimulus.
module tb_gnn_param;

    localparam int N   = 4;
    localparam int FI  = 4;
    localparam int FH  = 4;
    localparam int FO  = 2;
    localparam int DW  = 5;
    localparam int AW  = 21;
    localparam int LAT = N*(1+FH+FO);

    typedef struct packed {
        logic [DW-1:0]          xv;
        logic [DW-1:0]          w1v;
        logic [DW-1:0]          w2v;
        logic [N*N-1:0]         adj;
        logic [N-1:0][AW-1:0]   er;
        logic [N-1:0][AW-1:0]   en;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  out_ready;
    logic [N*FI*DW-1:0]    x_flat;
    logic [FI*FH*DW-1:0]   w1_flat;
    logic [FH*FO*DW-1:0]   w2_flat;
    logic [N*N-1:0]        adj;
    logic                  in_ready, in_ready_nr;
    logic                  out_valid, out_valid_nr;
    logic                  busy, busy_nr;
    logic [N*FO*AW-1:0]    out_flat, out_flat_nr;

    int errs = 0;
    int checks = 0;
    vec_t vecs[8];

    always #5 clk = ~clk;

    gnn_param #(.RELU(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x_flat(x_flat), .w1_flat(w1_flat), .w2_flat(w2_flat), .adj(adj),
        .out_valid(out_valid), .out_ready(out_ready), .out_flat(out_flat),
        .busy(busy)
    );

    gnn_param #(.RELU(0)) u_nr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_nr),
        .x_flat(x_flat), .w1_flat(w1_flat), .w2_flat(w2_flat), .adj(adj),
        .out_valid(out_valid_nr), .out_ready(out_ready), .out_flat(out_flat_nr),
        .busy(busy_nr)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int xv, input int w1v, input int w2v,
                                input logic [N*N-1:0] a, input int er,
                                input int en);
        vec_t v;
        v.xv  = DW'(xv);
        v.w1v = DW'(w1v);
        v.w2v = DW'(w2v);
        v.adj = a;
        for (int n = 0; n < N; n++) begin
            v.er[n] = AW'(er);
            v.en[n] = AW'(en);
        end
        return v;
    endfunction

    function automatic logic [AW-1:0] fld(input logic [N*FO*AW-1:0] f,
                                          input int i);
        return f[i*AW +: AW];
    endfunction

    task automatic apply(input vec_t v);
        x_flat  = {(N*FI){v.xv}};
        w1_flat = {(FI*FH){v.w1v}};
        w2_flat = {(FH*FO){v.w2v}};
        adj     = v.adj;
    endtask

    task automatic scramble();
        x_flat  = 80'({$urandom, $urandom, $urandom});
        w1_flat = 80'({$urandom, $urandom, $urandom});
        w2_flat = 40'({$urandom, $urandom});
        adj     = 16'($urandom);
    endtask

    task automatic accept();
        int b = 0;
        in_valid = 1'b1;
        while (!in_ready && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        @(posedge clk); #1;
        chk("accept_busy", longint'(busy), 1);
    endtask

    task automatic wait_out();
        int cnt = 0;
        while (!out_valid && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("latency", cnt, LAT);
        chk("valid_nr", longint'(out_valid_nr), 1);
    endtask

    task automatic check_out(input vec_t v, input int id);
        for (int n = 0; n < N; n++) begin
            for (int o = 0; o < FO; o++) begin
                chk($sformatf("v%0d_out[%0d][%0d]", id, n, o),
                    $signed(fld(out_flat, n*FO+o)), $signed(v.er[n]));
                chk($sformatf("v%0d_nr_out[%0d][%0d]", id, n, o),
                    $signed(fld(out_flat_nr, n*FO+o)), $signed(v.en[n]));
            end
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hs_valid_low", longint'(out_valid), 0);
        chk("hs_ready_high", longint'(in_ready), 1);
    endtask

    initial begin
        logic [N*FO*AW-1:0] held;
        int bad;

        vecs[0] = mk(1, 1, 1, 16'hFFFF, 64, 64);
        vecs[1] = mk(15, 15, 15, 16'h8421, 54000, 54000);
        vecs[2] = mk(15, 15, 15, 16'hFFFF, 216000, 216000);
        vecs[3] = mk(-16, -16, -16, 16'h8421, -65536, -65536);
        vecs[4] = mk(-16, -16, -16, 16'hFFFF, -262144, -262144);
        vecs[5] = mk(1, -1, 1, 16'h8421, 0, -16);
        vecs[6] = mk(1, 1, 1, 16'hF0FF, 64, 64);
        vecs[6].er[2] = '0;
        vecs[6].en[2] = '0;
        vecs[7] = mk(2, 3, -1, 16'h8421, -96, -96);

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        apply(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_out_zero", longint'(out_flat == '0), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            apply(vecs[i]);
            accept();
            in_valid = 1'b0;
            scramble();
            wait_out();
            check_out(vecs[i], i);
            handshake();
        end

        // Asynchronous reset while node 1 is in L1.
        apply(vecs[0]);
        accept();
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", longint'(in_ready), 1);
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_out_zero", longint'(out_flat == '0), 1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid || busy || !in_ready) bad++;
        end
        chk("midrst_quiet", bad, 0);

        // Output held under backpressure; in_valid ignored while in DONE.
        apply(vecs[1]);
        accept();
        scramble();
        wait_out();
        held = out_flat;
        apply(vecs[2]);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || busy || out_flat != held) bad++;
        end
        chk("hold_stable", bad, 0);
        check_out(vecs[1], 11);

        // Back-to-back: in_valid stays high through the output handshake.
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("b2b_idle_ready", longint'(in_ready), 1);
        chk("b2b_idle_valid", longint'(out_valid), 0);
        chk("b2b_idle_busy", longint'(busy), 0);
        @(posedge clk); #1;
        chk("b2b_accept_busy", longint'(busy), 1);
        in_valid = 1'b0;
        scramble();
        wait_out();
        check_out(vecs[2], 12);
        handshake();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
